// File: rtl/cmd_pkt_pkg.sv
// Shared framing types for the command path: UART stage, packet assembler and command buffer.
package cmd_pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GET_LEN,
    ST_GET_PAYLD,
    ST_GET_CHK
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_CHK  = 2'd2,
    ERR_TMO  = 2'd3
  } err_code_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/cmd_packet_assembler.sv
// Frames the UART byte stream (SYNC, LEN, payload, XOR checksum) into one wide payload word
// with a single-cycle write strobe for the command buffer.
module cmd_packet_assembler
  import cmd_pkt_pkg::*;
#(
  parameter int         MAX_PAYLD_PKT_BITS = 64,
  parameter int         TIMEOUT_CYCLES     = 120000,
  parameter logic [7:0] SYNC_BYTE          = SYNC_BYTE_DEF
) (
  input  logic                          i_clk,
  input  logic                          n_btn_rst,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_byte,
  output logic                          pkt_valid,
  output logic [MAX_PAYLD_PKT_BITS-1:0] pkt_data,
  output logic                          err_valid,
  output logic [1:0]                    err_code,
  output logic                          busy
);

  localparam int MAXB = MAX_PAYLD_PKT_BITS / 8;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

  state_t                        r_state;
  logic [CW-1:0]                 r_len;
  logic [CW-1:0]                 r_cnt;
  logic [7:0]                    r_chk;
  logic [TW-1:0]                 r_timer;
  logic [MAX_PAYLD_PKT_BITS-1:0] r_asm;
  logic [MAX_PAYLD_PKT_BITS-1:0] r_pkt_data;
  logic                          r_pkt_valid;
  logic                          r_err_valid;
  err_code_t                     r_err_code;

  logic w_len_ok;
  logic w_tmo;

  assign w_len_ok = (rx_byte != 8'd0) && (int'(rx_byte) <= MAXB);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign w_tmo    = (r_state != ST_IDLE) && !rx_valid &&
                    (r_timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge n_btn_rst) begin
    if (!n_btn_rst) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_chk       <= '0;
      r_timer     <= '0;
      r_asm       <= '0;
      r_pkt_data  <= '0;
      r_pkt_valid <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_pkt_valid <= 1'b0;
      r_err_valid <= 1'b0;

      if (rx_valid || r_state == ST_IDLE || w_tmo)
        r_timer <= '0;
      else
        r_timer <= r_timer + 1'b1;

      if (rx_valid) begin
        unique case (r_state)
          ST_IDLE: begin
            if (rx_byte == SYNC_BYTE) r_state <= ST_GET_LEN;
          end
          ST_GET_LEN: begin
            if (w_len_ok) begin
              r_len   <= CW'(rx_byte);
              r_chk   <= rx_byte;
              r_asm   <= '0;
              r_cnt   <= '0;
              r_state <= ST_GET_PAYLD;
            end else begin
              r_err_valid <= 1'b1;
              r_err_code  <= ERR_LEN;
              r_state     <= ST_IDLE;
            end
          end
          ST_GET_PAYLD: begin
            for (int k = 0; k < MAXB; k++)
              if (r_cnt == CW'(k)) r_asm[8*k +: 8] <= rx_byte;
            r_chk <= r_chk ^ rx_byte;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt + 1'b1 == r_len) r_state <= ST_GET_CHK;
          end
          ST_GET_CHK: begin
            if (rx_byte == r_chk) begin
              r_pkt_data  <= r_asm;
              r_pkt_valid <= 1'b1;
            end else begin
              r_err_valid <= 1'b1;
              r_err_code  <= ERR_CHK;
            end
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (w_tmo) begin
        r_err_valid <= 1'b1;
        r_err_code  <= ERR_TMO;
        r_state     <= ST_IDLE;
      end
    end
  end

  assign pkt_valid = r_pkt_valid;
  assign pkt_data  = r_pkt_data;
  assign err_valid = r_err_valid;
  assign err_code  = r_err_code;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cmd_packet_assembler.sv
// Directed bench for cmd_packet_assembler with a shortened timeout.
module tb_cmd_packet_assembler;

  localparam int TMO = 40;

  logic        i_clk = 1'b0;
  logic        n_btn_rst;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        pkt_valid;
  logic [63:0] pkt_data;
  logic        err_valid;
  logic [1:0]  err_code;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int pcount   = 0;
  int ecount   = 0;

  cmd_packet_assembler #(
    .MAX_PAYLD_PKT_BITS(64),
    .TIMEOUT_CYCLES    (TMO),
    .SYNC_BYTE         (8'hA5)
  ) dut (
    .i_clk    (i_clk),
    .n_btn_rst(n_btn_rst),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .pkt_valid(pkt_valid),
    .pkt_data (pkt_data),
    .err_valid(err_valid),
    .err_code (err_code),
    .busy     (busy)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (pkt_valid === 1'b1) pcount++;
    if (err_valid === 1'b1) ecount++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one byte for one full cycle; returns at the negedge after it was consumed.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    int n;
    int p0;
    int e0;
    n_btn_rst = 1'b0;
    rx_valid  = 1'b0;
    rx_byte   = 8'h00;
    repeat (3) @(negedge i_clk);
    chk("rst_pkt_valid", 64'(pkt_valid), 64'd0);
    chk("rst_pkt_data",  pkt_data,       64'd0);
    chk("rst_err_valid", 64'(err_valid), 64'd0);
    chk("rst_err_code",  64'(err_code),  64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    n_btn_rst = 1'b1;
    idle(2);

    // 1: good 3-byte frame
    send(8'hA5); send(8'h03); send(8'h07); send(8'h11); send(8'h22);
    chk("t1_busy_before_chk", 64'(busy), 64'd1);
    send(8'h37);
    chk("t1_pkt_valid", 64'(pkt_valid), 64'd1);
    chk("t1_pkt_data",  pkt_data,       64'h0000_0000_0022_1107);
    chk("t1_busy_after", 64'(busy), 64'd0);
    idle(1);
    chk("t1_pkt_valid_1cyc", 64'(pkt_valid), 64'd0);

    // 2: bad checksum
    p0 = pcount;
    send(8'hA5); send(8'h03); send(8'h07); send(8'h11); send(8'h22); send(8'h36);
    chk("t2_err_valid", 64'(err_valid), 64'd1);
    chk("t2_err_code",  64'(err_code),  64'd2);
    chk("t2_pkt_valid", 64'(pkt_valid), 64'd0);
    chk("t2_pkt_data_kept", pkt_data, 64'h0000_0000_0022_1107);
    idle(1);
    chk("t2_err_valid_1cyc", 64'(err_valid), 64'd0);
    chk("t2_err_code_held",  64'(err_code),  64'd2);
    chk("t2_no_pkt", 64'(pcount - p0), 64'd0);

    // 3: bad LEN values, then a good frame
    send(8'hA5); send(8'h00);
    chk("t3_len0_err_valid", 64'(err_valid), 64'd1);
    chk("t3_len0_err_code",  64'(err_code),  64'd1);
    idle(2);
    send(8'hA5); send(8'h09);
    chk("t3_len9_err_valid", 64'(err_valid), 64'd1);
    chk("t3_len9_err_code",  64'(err_code),  64'd1);
    chk("t3_len9_busy",      64'(busy),      64'd0);
    idle(1);
    send(8'hA5); send(8'h01); send(8'h42); send(8'h43);
    chk("t3_good_pkt_valid", 64'(pkt_valid), 64'd1);
    chk("t3_good_pkt_data",  pkt_data,       64'h42);
    chk("t3_err_code_held",  64'(err_code),  64'd1);
    idle(1);

    // LEN = MAXB boundary: checksum 08 ^ 01..08 = 00
    send(8'hA5); send(8'h08);
    for (int i = 1; i <= 8; i++) send(8'(i));
    send(8'h00);
    chk("maxb_pkt_valid", 64'(pkt_valid), 64'd1);
    chk("maxb_pkt_data",  pkt_data,       64'h0807_0605_0403_0201);
    idle(1);

    // 4: timeout mid-payload
    send(8'hA5); send(8'h02); send(8'h05);
    rx_valid = 1'b0;
    n = 0;
    while (err_valid !== 1'b1 && n < TMO + 10) begin
      @(negedge i_clk);
      n++;
    end
    chk("t4_tmo_cycles", 64'(n), 64'(TMO));
    chk("t4_err_code",   64'(err_code), 64'd3);
    chk("t4_busy",       64'(busy),     64'd0);
    idle(1);
    send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h13);
    chk("t4_next_pkt_valid", 64'(pkt_valid), 64'd1);
    chk("t4_next_pkt_data",  pkt_data,       64'hBBAA);
    idle(1);

    // 5: leading garbage, SYNC value as payload
    p0 = pcount;
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h01); send(8'hA5); send(8'hA4);
    chk("t5_pkt_data", pkt_data, 64'hA5);
    idle(3);
    chk("t5_one_pulse", 64'(pcount - p0), 64'd1);

    // 6: reset mid-payload is silent
    e0 = ecount;
    p0 = pcount;
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
    rx_valid  = 1'b0;
    n_btn_rst = 1'b0;
    @(negedge i_clk);
    chk("t6_rst_busy",      64'(busy),      64'd0);
    chk("t6_rst_pkt_data",  pkt_data,       64'd0);
    chk("t6_rst_err_code",  64'(err_code),  64'd0);
    chk("t6_rst_err_valid", 64'(err_valid), 64'd0);
    n_btn_rst = 1'b1;
    idle(2);
    chk("t6_no_err", 64'(ecount - e0), 64'd0);
    chk("t6_no_pkt", 64'(pcount - p0), 64'd0);

    // 6b: back-to-back frames, zero gap
    p0 = pcount;
    send(8'hA5); send(8'h01); send(8'h10); send(8'h11);
    chk("t6_b2b_first_data", pkt_data, 64'h10);
    send(8'hA5); send(8'h02); send(8'h20); send(8'h30); send(8'h12);
    chk("t6_b2b_second_data", pkt_data, 64'h3020);
    idle(2);
    chk("t6_b2b_pulses", 64'(pcount - p0), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
